b01_word_sink: RTL
==================

# b01_word_sink

Downstream collector for the b01 serial comparator. It samples the per-cycle OUTP and OVERFLW results that b01 produces and packs the OUTP bits LSB-first into WIDTH-bit words. Each word carries a sticky overflow tag and is buffered in a DEPTH-entry show-ahead FIFO. The FIFO is drained through a valid/ready port, so b01's one-bit-per-cycle stream can feed word-oriented logic without back-pressuring the serial FSM.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- DEPTH, 4: FIFO entries; power of two, 2..16.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- bit_valid  in  1  the OUTP/OVERFLW sample on this cycle is meaningful.
- outp  in  1  serial result bit from b01 (OUTP_REG).
- overflw  in  1  overflow indication from b01 (OVERFLW_REG).
- frame_start  in  1  discard any partial word and realign so the current or next valid bit is bit 0.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  WIDTH  head word; bit 0 is the first-received bit.
- out_ovf  out  1  set if any bit of the head word arrived with overflw=1.
- drop_cnt  out  8  words lost because the FIFO was full; saturates at 255.

## Operation
- Assembler state consists of shift register sr[WIDTH-1:0], bit index idx (0..WIDTH-1) and sticky ovf_acc.
- On bit_valid, outp is written to sr[idx] and ovf_acc is OR-ed with overflw.
  - If idx<WIDTH-1: idx increments.
  - If idx==WIDTH-1: the completed word {sr with new bit, ovf_acc|overflw} is offered to the FIFO; idx wraps to 0 and ovf_acc clears.
- frame_start=1: idx, ovf_acc and sr clear, and the partial word is discarded without being counted as a drop.
  - If bit_valid is also 1 on that cycle, the bit is taken as bit 0 of the new word (idx becomes 1).
  - With WIDTH ≥ 2, a frame_start cycle never completes a word.
- FIFO push happens on word completion.
  - When not full, or full with a pop on the same cycle, the word is written. The pop is evaluated first, so push and pop together on a full FIFO are both accepted and the count is unchanged.
  - When full with no pop, the word is dropped and drop_cnt increments, stopping at 255.
- FIFO pop happens when out_valid && out_ready. out_ready while empty has no effect.
- FIFO organisation: read and write pointers of log2(DEPTH)+1 bits.
  - empty when the pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap naturally at 2·DEPTH.
- The assembler runs a three-state FSM:
  - EMPTY_W: idx==0, no bits held.
  - FILL: 0<idx≤WIDTH-1.
  - COMPLETE is a transient condition (the completion cycle), not a held state. idx returns to 0, so after a completion the FSM is in EMPTY_W.
  - Transitions: EMPTY_W→FILL on bit_valid without frame_start, or on bit_valid with frame_start. FILL→EMPTY_W on frame_start without bit_valid, or on completion.

## Timing
- All outputs are registered or driven directly from FIFO storage and pointers; there are no combinational paths from inputs to outputs.
- Latency: out_valid rises on the cycle after the clock edge that sampled the last bit of a word, provided the FIFO was empty.
- Throughput: one bit per cycle sustained, so one word every WIDTH cycles; the FIFO needs one pop per WIDTH cycles to stay lossless.
- Reset values: out_valid=0, out_data=0, out_ovf=0, drop_cnt=0, idx=0, ovf_acc=0, pointers=0.
- Reset mid-word discards the partial word. Reset has priority over every other input on the same cycle.
- out_data/out_ovf hold stable while out_valid=1 and out_ready=0.

## Structure
- Shared package b01_pkg holds:
  - WIDTH and DEPTH defaults;
  - the word record type {data, ovf};
  - the FSM state enum {EMPTY_W, FILL};
  - the DROP_MAX=255 constant.
- One sub-module is natural: b01_sink_fifo (parameterised synchronous show-ahead FIFO, push/pop/full/empty). The assembler and drop counter stay in the top level.

## Test plan
- Basic pack: WIDTH=8, feed outp bits 1,0,1,1,0,0,0,1 on consecutive cycles, overflw=0, out_ready=1 → one cycle after the 8th bit, out_valid=1, out_data=8'h8D, out_ovf=0.
- Overflow tag: same stream with overflw=1 only on bit 3 → out_ovf=1; the next word with overflw=0 throughout → out_ovf=0.
- Gapped input and realign: 3 valid bits, then 5 idle cycles, then frame_start together with bit_valid, outp=1, then 7 bits of 0 → exactly one word, out_data=8'h01, drop_cnt=0.
- Full FIFO: out_ready=0, 5 words of 8'hAA/55/F0/0F/33 (DEPTH=4) → drop_cnt=1; draining returns AA,55,F0,0F in order; out_valid then falls.
- Simultaneous push/pop on full: FIFO full, word 6 completes on the same cycle out_ready=1 → no drop, the count stays 4, and word 6 emerges after 3 more pops.
- Reset mid-word and saturation: reset after 4 bits → all outputs 0, and the next 8 bits form a clean word. Separately, 300 drops → drop_cnt=255.

Source files
------------

// File: rtl/b01_pkg.sv
// Shared types and constants for the b01 word sink: default geometry, word record,
// assembler state encoding and the drop counter ceiling.
package b01_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 4;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Word record at the default width; the top level carries the same {data, ovf}
  // layout through the FIFO for any WIDTH.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] data;
    logic                     ovf;
  } word_t;

  typedef enum logic {
    EMPTY_W = 1'b0,
    FILL    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/b01_sink_fifo.sv
// Parameterised synchronous show-ahead FIFO; the head word is read straight from storage.
// Pointers carry one extra MSB so full and empty are distinguishable.
module b01_sink_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot on the same edge, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wr_data;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/b01_word_sink.sv
// Packs b01's serial OUTP stream LSB-first into WIDTH-bit words tagged with a sticky
// overflow flag, buffers them in a show-ahead FIFO and counts words lost to a full FIFO.
module b01_word_sink
  import b01_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             outp,
  input  logic             overflw,
  input  logic             frame_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [7:0]       drop_cnt
);

  localparam int IDXW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_new;
  logic [IDXW-1:0]  idx;
  logic             ovf_acc;
  asm_state_t       state;

  logic             last_bit;
  logic             complete;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH:0]   fifo_rd;

  always_comb begin
    sr_new      = sr;
    sr_new[idx] = outp;
  end

  assign last_bit  = (idx == IDXW'(WIDTH - 1));
  assign complete  = bit_valid && !frame_start && (state == FILL) && last_bit;
  assign pop       = out_valid && out_ready;
  assign drop      = complete && fifo_full && !pop;

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd[WIDTH:1];
  assign out_ovf   = fifo_rd[0];

  b01_sink_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (complete),
    .wr_data ({sr_new, ovf_acc | overflw}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // frame_start realigns unconditionally; a bit arriving with it becomes bit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr       <= '0;
      idx      <= '0;
      ovf_acc  <= 1'b0;
      state    <= EMPTY_W;
      drop_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != DROP_MAX)) drop_cnt <= drop_cnt + 8'd1;

      if (frame_start) begin
        sr      <= bit_valid ? {{(WIDTH-1){1'b0}}, outp} : '0;
        idx     <= bit_valid ? IDXW'(1) : '0;
        ovf_acc <= bit_valid & overflw;
        state   <= bit_valid ? FILL : EMPTY_W;
      end else if (bit_valid) begin
        if (complete) begin
          sr      <= '0;
          idx     <= '0;
          ovf_acc <= 1'b0;
          state   <= EMPTY_W;
        end else begin
          sr      <= sr_new;
          idx     <= idx + IDXW'(1);
          ovf_acc <= ovf_acc | overflw;
          state   <= FILL;
        end
      end
    end
  end

endmodule
